iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/iter_muldiv.sv | 127 ++++++++++++
 rtl/iter_alu.sv | 151 +++++++++++++++
 tb/tb_iter_alu.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: operation encoding, controller states and
// the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [4:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND,
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } alu_state_t;

    function automatic logic is_mul_op(input alu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring-division step per
// cycle on operand magnitudes, WIDTH steps per operation, signs fixed on exit.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic             busy_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             is_div_reg;
    logic             sel_upper_reg;
    logic             neg_reg;

    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             start_div;
    logic             start_upper;
    logic             start_neg;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   trial_sub;
    logic               ge;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   sh_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   div_mag;

    // Operand decode at start: which operands are signed and their magnitudes.
    always_comb begin
        a_signed    = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed    = op inside {OP_MULH, OP_DIV, OP_REM};
        a_neg       = a_signed & a[WIDTH-1];
        b_neg       = b_signed & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        start_div   = is_div_op(op);
        start_upper = !(op inside {OP_MUL, OP_DIV, OP_DIVU});
        // A remainder takes the dividend's sign; everything else the product of signs.
        start_neg   = (op inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        mul_sum   = {1'b0, acc_reg} + (sh_reg[0] ? {1'b0, opnd_reg} : '0);
        trial     = {acc_reg, sh_reg[WIDTH-1]};
        ge        = trial >= {1'b0, opnd_reg};
        // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
        trial_sub = trial[WIDTH-1:0] - opnd_reg;

        if (is_div_reg) begin
            acc_next = ge ? trial_sub : trial[WIDTH-1:0];
            sh_next  = {sh_reg[WIDTH-2:0], ge};
        end else begin
            acc_next = mul_sum[WIDTH:1];
            sh_next  = {mul_sum[0], sh_reg[WIDTH-1:1]};
        end

        prod    = neg_reg ? -{acc_next, sh_next} : {acc_next, sh_next};
        div_mag = sel_upper_reg ? acc_next : sh_next;

        if (is_div_reg) begin
            res = neg_reg ? -div_mag : div_mag;
        end else begin
            res = sel_upper_reg ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        end
    end

    // res is valid combinationally during the final step so the caller can
    // capture it on the same edge the last iteration completes.
    assign done = busy_reg && (count_reg == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg      <= 1'b0;
            count_reg     <= '0;
            acc_reg       <= '0;
            sh_reg        <= '0;
            opnd_reg      <= '0;
            is_div_reg    <= 1'b0;
            sel_upper_reg <= 1'b0;
            neg_reg       <= 1'b0;
        end else if (abort) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
        end else if (start) begin
            busy_reg      <= 1'b1;
            count_reg     <= '0;
            acc_reg       <= '0;
            sh_reg        <= start_div ? a_mag : b_mag;
            opnd_reg      <= start_div ? b_mag : a_mag;
            is_div_reg    <= start_div;
            sel_upper_reg <= start_upper;
            neg_reg       <= start_neg;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            sh_reg  <= sh_next;
            if (done) begin
                busy_reg  <= 1'b0;
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// RV32I/M-style ALU with valid/ready handshakes: single-cycle ops and division
// corner cases finish in one cycle, multiply/divide run through iter_muldiv.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_t       state_reg;
    alu_state_t       state_next;
    logic             ready_en_reg;
    logic [WIDTH-1:0] result_reg;
    logic             div_zero_reg;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] fast_res;
    logic             fast_dz;
    logic             bypass;
    logic             md_start;
    logic             md_abort;
    logic             md_done;
    logic [WIDTH-1:0] md_res;

    assign accept   = in_valid && (state_reg == ST_IDLE) && ready_en_reg;
    assign md_start = accept && (is_mul_op(op) || (is_div_op(op) && !bypass));
    assign md_abort = flush && (state_reg != ST_IDLE);

    // Single-cycle results, plus the two division cases that never iterate.
    always_comb begin
        fast_res = '0;
        fast_dz  = 1'b0;
        bypass   = 1'b0;
        shamt    = op2[SHW-1:0];
        case (op)
            OP_ADD:  fast_res = op1 + op2;
            OP_SUB:  fast_res = op1 - op2;
            OP_SLL:  fast_res = op1 << shamt;
            OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, op1 < op2};
            OP_XOR:  fast_res = op1 ^ op2;
            OP_SRL:  fast_res = op1 >> shamt;
            OP_SRA:  fast_res = $signed(op1) >>> shamt;
            OP_OR:   fast_res = op1 | op2;
            OP_AND:  fast_res = op1 & op2;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (op2 == '0) begin
                    bypass   = 1'b1;
                    fast_dz  = 1'b1;
                    fast_res = (op inside {OP_DIV, OP_DIVU}) ? '1 : op1;
                end else if ((op inside {OP_DIV, OP_REM}) && op1 == MOST_NEG && op2 == '1) begin
                    bypass   = 1'b1;
                    fast_res = (op == OP_DIV) ? op1 : '0;
                end
            end
            default: fast_res = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = ready_en_reg;
                if (accept) begin
                    state_next = md_start ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (md_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg   <= '0;
            div_zero_reg <= 1'b0;
        end else if (accept && !md_start) begin
            result_reg   <= fast_res;
            div_zero_reg <= fast_dz;
        end else if (state_reg == ST_CALC && md_done && !flush) begin
            result_reg   <= md_res;
            div_zero_reg <= 1'b0;
        end
    end

    assign result   = result_reg;
    assign div_zero = div_zero_reg;

    iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .abort (md_abort),
        .op    (op),
        .a     (op1),
        .b     (op2),
        .done  (md_done),
        .res   (md_res)
    );

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed corner cases, flush/reset aborts,
// back-to-back traffic and randomized operations against an arithmetic model.
module tb_iter_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    alu_op_t      op = OP_ADD;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         div_zero;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .div_zero  (div_zero)
    );

    // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic void ref_model(input alu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] r, output logic dz, output int lat);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = '0;
        dz = 1'b0;
        lat = 1;
        case (o)
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_SLL:    r = a << b[4:0];
            OP_SLT:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:   r = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:    r = a ^ b;
            OP_SRL:    r = a >> b[4:0];
            OP_SRA:    r = $signed(a) >>> b[4:0];
            OP_OR:     r = a | b;
            OP_AND:    r = a & b;
            OP_MUL:    begin p = ua * ub; r = p[31:0];  lat = 33; end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; lat = 33; end
            OP_MULHSU: begin p = sa * ub; r = p[63:32]; lat = 33; end
            OP_MULHU:  begin p = ua * ub; r = p[63:32]; lat = 33; end
            OP_DIV: begin
                if (b == 0) begin r = '1; dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin r = $signed(a) / $signed(b); lat = 33; end
            end
            OP_REM: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else begin r = $signed(a) % $signed(b); lat = 33; end
            end
            OP_DIVU: begin
                if (b == 0) begin r = '1; dz = 1'b1; end
                else begin r = a / b; lat = 33; end
            end
            OP_REMU: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else begin r = a % b; lat = 33; end
            end
            default: r = '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Drives one request, scrambles the inputs after acceptance, waits for the
    // result, stalls out_ready for 'stall' cycles and performs the handoff.
    task automatic run_op(input alu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                          output logic [W-1:0] r, output logic dz, output int lat,
                          output logic stable, output logic handoff_ok);
        int n;
        stable = 1'b1;
        handoff_ok = 1'b0;
        r = '0;
        dz = 1'b0;
        lat = 999;
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            $display("[TB] %s request never accepted", o.name());
            return;
        end
        in_valid = 1'b1;
        op = o;
        op1 = a;
        op2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = alu_op_t'(5'($urandom_range(0, 17)));
        op1 = $urandom;
        op2 = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        dz = div_zero;
        if (in_ready !== 1'b0) stable = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || result !== r || div_zero !== dz || in_ready !== 1'b0) stable = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        handoff_ok = (out_valid === 1'b0 && in_ready === 1'b1);
        $display("[TB] %-6s a=%h b=%h -> result=%h dz=%0d lat=%0d", o.name(), a, b, r, dz, lat);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (result !== '0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result); end
        tests_run++;
        if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL release_in_ready_pre_edge got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready_post_edge got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        alu_op_t      d_op  [10];
        logic [W-1:0] d_a   [10];
        logic [W-1:0] d_b   [10];
        logic [W-1:0] d_exp [10];
        logic         d_dz  [10];
        int           d_lat [10];
        logic [W-1:0] r;
        logic         dz, stable, hs;
        int           lat;
        d_op  = '{OP_ADD, OP_SLT, OP_SLTU, OP_SRA, OP_MULH, OP_MUL, OP_DIV, OP_REM, OP_DIV, OP_AND};
        d_a   = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD,
                  32'hFFFF_FFFD, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'h0000_F0F0};
        d_b   = '{32'd1, 32'd1, 32'd1, 32'h21, 32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FF00};
        d_exp = '{32'h8000_0000, 32'd1, 32'd0, 32'hC000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
                  32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h0000_F000};
        d_dz  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        d_lat = '{1, 1, 1, 1, 33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 0, r, dz, lat, stable, hs);
            tests_run++;
            if (r !== d_exp[i]) begin tests_failed++; $display("FAIL directed_%0d_%s result got %h want %h", i, d_op[i].name(), r, d_exp[i]); end
            tests_run++;
            if (dz !== d_dz[i]) begin tests_failed++; $display("FAIL directed_%0d_%s div_zero got %b want %b", i, d_op[i].name(), dz, d_dz[i]); end
            tests_run++;
            if (lat !== d_lat[i]) begin tests_failed++; $display("FAIL directed_%0d_%s latency got %0d want %0d", i, d_op[i].name(), lat, d_lat[i]); end
            tests_run++;
            if (hs !== 1'b1) begin tests_failed++; $display("FAIL directed_%0d_%s handoff got %b want 1", i, d_op[i].name(), hs); end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] r;
        logic         dz, stable, hs;
        int           lat;
        run_op(OP_DIVU, 32'd100, 32'd7, 5, r, dz, lat, stable, hs);
        tests_run++;
        if (r !== 32'd14) begin tests_failed++; $display("FAIL hold_divu_result got %0d want 14", r); end
        tests_run++;
        if (lat !== 33) begin tests_failed++; $display("FAIL hold_divu_latency got %0d want 33", lat); end
        tests_run++;
        if (stable !== 1'b1) begin tests_failed++; $display("FAIL hold_divu_stable got %b want 1", stable); end
        tests_run++;
        if (hs !== 1'b1) begin tests_failed++; $display("FAIL hold_divu_handoff got %b want 1", hs); end
    endtask

    task automatic test_flush();
        logic [W-1:0] r;
        logic         dz, stable, hs, seen;
        int           lat;

        // Flush partway through a division.
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIV; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_calc_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_calc_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_calc_late_result got %b want 0", seen); end

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; op = OP_MUL; op1 = 32'd12345; op2 = 32'd678;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== '0 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_calc outputs got ov=%b ir=%b res=%h dz=%b want 0 0 0 0", out_valid, in_ready, result, div_zero);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_calc_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_calc_late_result got %b want 0", seen); end

        run_op(OP_ADD, 32'd2, 32'd2, 0, r, dz, lat, stable, hs);
        tests_run++;
        if (r !== 32'd4 || lat !== 1) begin tests_failed++; $display("FAIL after_abort_add got %0d lat %0d want 4 lat 1", r, lat); end

        // Flush while a result waits in DONE.
        @(negedge clk);
        in_valid = 1'b1; op = OP_XOR; op1 = 32'h1234_5678; op2 = 32'hFFFF_0000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_done got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end

        // Flush in IDLE must not block acceptance.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = OP_ADD; op1 = 32'd5; op2 = 32'd6;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'd11) begin
            tests_failed++;
            $display("FAIL flush_idle_accept got ov=%b res=%0d want 1 11", out_valid, result);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pending;
        logic         accepted;
        int           results;
        results = 0;
        pending = '0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; op1 = 32'd0; op2 = 32'd100;
        for (int i = 0; i < 8; i++) begin
            accepted = (in_ready === 1'b1);
            if (accepted) pending = op1 + op2;
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                results++;
                tests_run++;
                if (result !== pending || in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_%0d result got %0d ir=%b want %0d ir=0", i, result, in_ready, pending);
                end
            end
            @(negedge clk);
            if (accepted) op1 = op1 + 1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (results !== 4) begin tests_failed++; $display("FAIL b2b_result_count got %0d want 4", results); end
        $display("[TB] back-to-back: %0d results in 8 cycles", results);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random();
        alu_op_t      o;
        logic [W-1:0] a, b, r, exp_r;
        logic         dz, exp_dz, stable, hs;
        int           lat, exp_lat, stall;
        for (int i = 0; i < 80; i++) begin
            o = alu_op_t'(5'($urandom_range(0, 17)));
            a = rand_operand();
            b = rand_operand();
            stall = $urandom_range(0, 2);
            ref_model(o, a, b, exp_r, exp_dz, exp_lat);
            run_op(o, a, b, stall, r, dz, lat, stable, hs);
            tests_run++;
            if (r !== exp_r) begin tests_failed++; $display("FAIL rand_%0d_%s result a=%h b=%h got %h want %h", i, o.name(), a, b, r, exp_r); end
            tests_run++;
            if (dz !== exp_dz) begin tests_failed++; $display("FAIL rand_%0d_%s div_zero got %b want %b", i, o.name(), dz, exp_dz); end
            tests_run++;
            if (lat !== exp_lat) begin tests_failed++; $display("FAIL rand_%0d_%s latency got %0d want %0d", i, o.name(), lat, exp_lat); end
            tests_run++;
            if (stable !== 1'b1 || hs !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand_%0d_%s handshake stable=%b handoff=%b want 1 1", i, o.name(), stable, hs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_flush();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
